// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Latency: n/a (compile-time only).  Backpressure: n/a.
package tick_gen_pkg;

    localparam int CLK_50M_HZ   = 50_000_000;
    localparam int BASE_1MS_CYC = 50_000;

    // Channel-select width; a single channel still needs a 1-bit select port.
    function automatic int ch_w_of(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counts base ticks up to a programmable period, periodic or one-shot.
// Latency: tick is high the cycle after the completing base tick.  Backpressure: none, pulses are fire-and-forget.
module tick_channel #(
    parameter int PER_W = 16
) (
    input  logic             clk_50m,
    input  logic             reset,
    input  logic             base_tick,
    input  logic             enable,
    input  logic             restart,
    input  logic             cfg_wr,
    input  logic [PER_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    output logic             tick,
    output logic             active
);

    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             oneshot_q, oneshot_d;
    logic             active_q, active_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        active_d  = active_q;
        tick_d    = 1'b0;
        // A write or restart swallows a coincident base tick so counting starts cleanly at 0.
        if (cfg_wr) begin
            period_d  = cfg_period;
            oneshot_d = cfg_oneshot;
            cnt_d     = '0;
            active_d  = 1'b1;
        end else if (restart) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (base_tick && enable && active_q && (period_q != '0)) begin
            if (cnt_q == period_q - PER_W'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (oneshot_q) begin
                    active_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            cnt_q     <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            active_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            active_q  <= active_d;
            tick_q    <= tick_d;
        end
    end

    assign tick   = tick_q;
    assign active = active_q;

endmodule

// File: rtl/tick_generator_multi.sv
// Shared prescaler plus NUM_CH programmable tick channels for LCD, scroll, debounce and timeout consumers.
// Latency: base_tick every BASE_PERIOD_CYC cycles; channel ticks one cycle after the completing base tick.  Backpressure: none.
module tick_generator_multi
    import tick_gen_pkg::*;
#(
    parameter int  BASE_PERIOD_CYC = BASE_1MS_CYC,
    parameter int  NUM_CH          = 4,
    parameter int  PER_W           = 16,
    localparam int CH_W            = ch_w_of(NUM_CH)
) (
    input  logic              clk_50m,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] ch_restart,
    output logic              base_tick,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] ch_active
);

    localparam int                   PRESC_W    = $clog2(BASE_PERIOD_CYC);
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(BASE_PERIOD_CYC - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               base_tick_q, base_tick_d;

    always_comb begin
        presc_d     = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        base_tick_d = (presc_q == PRESC_LAST);
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
        end
    end

    assign base_tick = base_tick_q;

    // Out-of-range selects never match any channel index, so such writes fall away.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic cfg_wr;
        assign cfg_wr = cfg_we && (cfg_ch == CH_W'(i));

        tick_channel #(
            .PER_W (PER_W)
        ) u_ch (
            .clk_50m     (clk_50m),
            .reset       (reset),
            .base_tick   (base_tick_q),
            .enable      (ch_enable[i]),
            .restart     (ch_restart[i]),
            .cfg_wr      (cfg_wr),
            .cfg_period  (cfg_period),
            .cfg_oneshot (cfg_oneshot),
            .tick        (tick[i]),
            .active      (ch_active[i])
        );
    end

endmodule
